// File: rtl/e_muldiv_pkg.sv
// Shared constants and types for the E-stage multiply/divide unit.
// Holds the MD_* op encodings, data and op widths, the default latencies and
// the result payload. The ID decoder and the hazard unit import it as well.
package e_muldiv_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  // Result of one arithmetic op as it waits to be committed to HI/LO.
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              div_zero;
  } md_res_t;

endpackage

// File: rtl/e_muldiv_if.sv
// Operand/op bus between the ID/EX register and the mul/div unit.
// master: pipeline side (drives start/op/operands, observes busy/hi/lo).
// slave : mul/div unit side.
interface e_muldiv_if;
  import e_muldiv_pkg::*;

  logic              start;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] inRegRead1;
  logic [DATA_W-1:0] inRegRead2;
  logic              busy;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, inRegRead1, inRegRead2,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, inRegRead1, inRegRead2,
    output busy, hi, lo
  );

endinterface

// File: rtl/e_muldiv_muldiv_alu.sv
// Combinational multiply/divide datapath.
// Ports: op (MD_* code), a (rs), b (rt) -> res_c {hi, lo, div_zero}.
// Ops other than MULT/MULTU/DIV/DIVU produce an all-zero result.
module muldiv_alu
  import e_muldiv_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output md_res_t           res_c
);

  logic signed [2*DATA_W-1:0] sa, sb, prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic                       b_zero, s_ovf;
  logic        [DATA_W-1:0]   b_sdiv, b_udiv;
  logic signed [DATA_W-1:0]   quo_s, rem_s;
  logic        [DATA_W-1:0]   quo_u, rem_u;

  assign sa     = {{DATA_W{a[DATA_W-1]}}, a};
  assign sb     = {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_s = sa * sb;
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Divisor is replaced by 1 for x/0 (result discarded anyway) and for
  // INT_MIN/-1, where x/1 yields exactly the required quotient 0x80000000, rem 0.
  assign b_zero = (b == '0);
  assign s_ovf  = (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1);
  assign b_sdiv = (b_zero || s_ovf) ? DATA_W'(1) : b;
  assign b_udiv = b_zero ? DATA_W'(1) : b;

  assign quo_s = $signed(a) / $signed(b_sdiv);
  assign rem_s = $signed(a) % $signed(b_sdiv);
  assign quo_u = a / b_udiv;
  assign rem_u = a % b_udiv;

  // Select the result for the requested op.
  always_comb begin
    res_c = '0;
    case (op)
      MD_MULT:  {res_c.hi, res_c.lo} = prod_s;
      MD_MULTU: {res_c.hi, res_c.lo} = prod_u;
      MD_DIV: begin
        res_c.hi       = rem_s;
        res_c.lo       = quo_s;
        res_c.div_zero = b_zero;
      end
      MD_DIVU: begin
        res_c.hi       = rem_u;
        res_c.lo       = quo_u;
        res_c.div_zero = b_zero;
      end
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/e_muldiv.sv
// E-stage multi-cycle multiply/divide unit owning the HI/LO registers.
// Ports: clk, reset (async, active-low), bus (slave: start, op, inRegRead1,
// inRegRead2 in; busy, hi, lo out, all registered).
// The result is computed when the op is accepted and held in a pending
// register; the counter only models latency, after which HI/LO commit.
module e_muldiv
  import e_muldiv_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
)(
  input  logic     clk,
  input  logic     reset,
  e_muldiv_if.slave bus
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  md_res_t           pend, pend_nxt;
  logic [DATA_W-1:0] hi_q, hi_nxt, lo_q, lo_nxt;
  logic              busy_q, busy_nxt;
  md_res_t           alu_res_c;

  muldiv_alu u_alu (
    .op    (bus.op),
    .a     (bus.inRegRead1),
    .b     (bus.inRegRead2),
    .res_c (alu_res_c)
  );

  // State and architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      pend   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pend   <= pend_nxt;
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Next-state, counter, pending result and HI/LO update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            MD_MULT, MD_MULTU: begin
              state_nxt = S_RUN;
              cnt_nxt   = CNT_W'(MULT_LAT);
              pend_nxt  = alu_res_c;
            end
            MD_DIV, MD_DIVU: begin
              state_nxt = S_RUN;
              cnt_nxt   = CNT_W'(DIV_LAT);
              pend_nxt  = alu_res_c;
            end
            MD_MTHI: hi_nxt = bus.inRegRead1;
            MD_MTLO: lo_nxt = bus.inRegRead1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // start is ignored here; only the counter advances.
        if (cnt <= CNT_W'(1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          pend_nxt  = '0;
          if (!pend.div_zero) begin
            hi_nxt = pend.hi;
            lo_nxt = pend.lo;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt == S_RUN);
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_e_muldiv.sv
// Self-checking bench for e_muldiv: a reference model pushes expected HI/LO
// and latency into a scoreboard when an op is driven; entries are popped and
// compared when busy falls.
module tb_e_muldiv;
  import e_muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  e_muldiv_if bus ();

  e_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  // Reference model: updates model HI/LO and queues the expected commit.
  task automatic model_push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          p, sa, sb, q, r;
    longint unsigned pu;
    exp_t            e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.lat = (op == MD_MULT || op == MD_MULTU) ? MULT_LAT_DEF : DIV_LAT_DEF;
    case (op)
      MD_MULT: begin
        p = sa * sb;
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      MD_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        m_hi = pu[63:32]; m_lo = pu[31:0];
      end
      MD_DIV: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        m_hi = 32'(r); m_lo = 32'(q);
      end
      MD_DIVU: if (b != 0) begin
        m_hi = a % b; m_lo = a / b;
      end
      default: ;
    endcase
    e.hi = m_hi; e.lo = m_lo;
    sb_q.push_back(e);
  endtask

  // Counts negedges with busy high; returns at the first negedge with busy low.
  task automatic wait_done(output int n, output bit timeout);
    n = 0; timeout = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) begin timeout = 1'b0; break; end
      n++;
    end
  endtask

  // Pops one scoreboard entry and compares it to the DUT state.
  task automatic sb_check(input string name, input int nbusy, input bit timeout);
    exp_t e;
    checks++;
    if (timeout || sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: busy never fell or empty scoreboard (timeout=%0d)", name, timeout);
      return;
    end
    e = sb_q.pop_front();
    if (nbusy !== e.lat) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, nbusy, e.lat);
    end
    checks++;
    if (bus.hi !== e.hi || bus.lo !== e.lo) begin
      failures++;
      $display("FAIL %s hi/lo: got %h/%h expected %h/%h", name, bus.hi, bus.lo, e.hi, e.lo);
    end
  endtask

  // Drives one op at the current negedge, then runs it to completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    int n; bit to;
    bus.start = 1'b1; bus.op = op; bus.inRegRead1 = a; bus.inRegRead2 = b;
    if (op <= MD_DIVU) model_push(op, a, b);
    else if (op == MD_MTHI) m_hi = a;
    else if (op == MD_MTLO) m_lo = a;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.inRegRead1 = $urandom; bus.inRegRead2 = $urandom;
    if (op <= MD_DIVU) begin
      wait_done(n, to);
      sb_check(name, n, to);
    end else begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
        failures++;
        $display("FAIL %s: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                 name, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] hi_e, input logic [31:0] lo_e);
    checks++;
    if (bus.hi !== hi_e || bus.lo !== lo_e) begin
      failures++;
      $display("FAIL %s: got %h/%h expected %h/%h", name, bus.hi, bus.lo, hi_e, lo_e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'b1; bus.op = 3'($urandom_range(0, 7));
      bus.inRegRead1 = $urandom; bus.inRegRead2 = $urandom;
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_mult();
    run_op(MD_MULT, 32'hFFFFFFFE, 32'h00000003, "mult");
    check_lit("mult_lit", 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op(MD_MULTU, 32'hFFFFFFFE, 32'h00000003, "multu");
    check_lit("multu_lit", 32'h00000002, 32'hFFFFFFFA);
    for (int i = 0; i < 4; i++)
      run_op(3'($urandom_range(0, 1)), $urandom, $urandom, "mult_rand");
  endtask

  task automatic test_div();
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, "div_neg");
    check_lit("div_neg_lit", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(MD_DIVU, 32'd7, 32'd2, "divu");
    check_lit("divu_lit", 32'd1, 32'd3);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    check_lit("div_ovf_lit", 32'd0, 32'h80000000);
    for (int i = 0; i < 4; i++)
      run_op(3'($urandom_range(2, 3)), $urandom, 32'($urandom_range(1, 1000)), "div_rand");
  endtask

  task automatic test_div_zero();
    run_op(MD_MTHI, 32'h1234, 32'd0, "mthi");
    run_op(MD_MTLO, 32'h5678, 32'd0, "mtlo");
    run_op(MD_DIV, 32'd99, 32'd0, "div_zero");
    check_lit("div_zero_lit", 32'h1234, 32'h5678);
    run_op(MD_DIVU, 32'd5, 32'd0, "divu_zero");
    run_op(3'd6, 32'hDEAD, 32'hBEEF, "op6_ignored");
  endtask

  task automatic test_start_while_busy();
    int n; bit to;
    bus.start = 1'b1; bus.op = MD_DIV; bus.inRegRead1 = 32'd100; bus.inRegRead2 = 32'd7;
    model_push(MD_DIV, 32'd100, 32'd7);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0; to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) begin to = 1'b0; break; end
      n++;
      bus.start = (n == 3);
      bus.op = MD_MULT; bus.inRegRead1 = 32'd3; bus.inRegRead2 = 32'd5;
    end
    bus.start = 1'b0;
    sb_check("div_ignore_start", n, to);
  endtask

  task automatic test_back_to_back();
    run_op(MD_MULT, 32'd6, 32'd7, "b2b_mult");
    run_op(MD_DIVU, 32'd100, 32'd9, "b2b_divu");
    run_op(MD_MTLO, 32'hCAFE, 32'd0, "b2b_mtlo");
  endtask

  task automatic test_reset_mid_op();
    bus.start = 1'b1; bus.op = MD_MULT; bus.inRegRead1 = 32'd9; bus.inRegRead2 = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_op: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL no_commit_after_reset: busy=%b hi=%h lo=%h expected 0/0/0",
               bus.busy, bus.hi, bus.lo);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.inRegRead1 = '0; bus.inRegRead2 = '0;
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
